be_sequencer: RTL
=================

// Module: be_sequencer
// PURPOSE
//  Parametrised microcode sequencer for the 8-bit bus CPU. It is the successor to the fixed
//  five-stage controller, and drives the control word that gates every bus driver and register enable.
//  New behaviour: per-opcode step length, carry/zero flags with conditional jumps, a HALT state
//  with resume, and a single-step debug mode.
//  Sits between the instruction register (opcode in) and the datapath (control word out).
// PARAMETERS
//  OPW    4   opcode width (instruction upper bits)
//  STEPS  8   max microsteps per instruction; step counter width = $clog2(STEPS)
//  CW     16  control word width (bit indices fixed in be_pkg; CW >= 16)
// PORTS
//  CLK        in   1     clock; all state updates on posedge CLK
//  rst        in   1     reset, synchronous, active-high
//  opcode     in   OPW   instruction register upper field, stable outside step 1
//  alu_carry  in   1     ALU carry out
//  alu_zero   in   1     ALU result == 0
//  run_mode   in   1     1 = free run; 0 = single-step
//  step_req   in   1     single-step request level; its rising edge grants one step
//  resume     in   1     level; leaves HALT
//  ctrl_word  out  CW    decoded control word, masked to 0 when adv=0 or halted
//  ctrl_raw   out  CW    unmasked decode, for LED display
//  adv        out  1     1 = the current cycle commits (the step advances at the next edge)
//  step       out  $clog2(STEPS)  current microstep
//  halted     out  1     FSM is in HALT
//  flag_c     out  1     registered carry flag
//  flag_z     out  1     registered zero flag
// BEHAVIOUR
//  Reset: state=RUN, step=0, flag_c=0, flag_z=0, step_req edge detector cleared, halted=0.
//   After reset, ctrl_word = MI|CO if run_mode=1, else 0.
//  adv = (state==RUN) & (run_mode | (step_req & ~step_req_q)).
//   step_req_q is registered every cycle.
//  Decode is combinational from (step, opcode, flag_c, flag_z); ctrl_word = adv ? ctrl_raw : 0.
//  Fetch, all opcodes:
//   step 0: MI|CO
//   step 1: RO|II|CE
//  Execute, step 2 and later:
//   NOP: none (LEN 2)
//   LDA: IO|MI, then RO|AI (LEN 4)
//   ADD: IO|MI, then RO|BI, then SO|AI|FI (LEN 5)
//   SUB: as ADD, with SU added to every execute step (LEN 5)
//   STA: IO|MI, then AO|RI (LEN 4)
//   LDI: IO|AI (LEN 3)
//   JMP: IO|J (LEN 3)
//   JC:  IO|J if flag_c, else 0 (LEN 3)
//   JZ:  IO|J if flag_z, else 0 (LEN 3)
//   OUT: AO|OI (LEN 3)
//   HLT: HLT (LEN 3)
//   Undefined opcodes decode as NOP.
//  Step advance, on an edge with adv=1:
//   step <= (step == LEN(opcode)-1 || step == STEPS-1) ? 0 : step+1
//   The STEPS-1 cap is a forced wrap and takes priority.
//  Flags: on an edge with adv & FI, flag_c <= alu_carry and flag_z <= alu_zero.
//   Otherwise the flags hold. A conditional jump reads the flags from the last FI.
//  FSM:
//   RUN -> HALT on an edge with adv and the HLT bit set; step <= 0.
//   HALT: ctrl_word=0, step holds at 0, halted=1, flags hold, step_req edges are ignored.
//   HALT -> RUN on an edge with resume=1; execution resumes at fetch step 0.
//   resume=1 while in RUN has no effect.
//  With adv=0, all state except step_req_q holds.
//  rst wins over every other input, in any state and at any step.
//   Reset mid-instruction aborts it and returns to fetch step 0.
//  A change of run_mode mid-instruction takes effect on the next cycle; the step is unaffected.
// STRUCTURE
//  be_pkg:
//   opcode localparams: NOP=0 LDA=1 ADD=2 SUB=3 STA=4 LDI=5 JMP=6 JC=7 JZ=8 OUT=14 HLT=15
//   ctrl bit indices: J=0 CO=1 CE=2 OI=3 BI=4 SU=5 SO=6 AO=7 AI=8 II=9 IO=10 RO=11 RI=12
//    MI=13 HLT=14 FI=15
//   function be_len(opcode)
//  Sub-module be_microcode_rom: combinational (step, opcode, flag_c, flag_z) -> ctrl_raw.
//  The top level holds the step counter, the FSM, the flags and the edge detector.
// TESTING
//  LDA, run_mode=1: ctrl_word over 4 cycles = MI|CO, RO|II|CE, IO|MI, RO|AI; step back to 0 on cycle 5.
//  ADD, alu_carry=1, alu_zero=0: step-4 word = SO|AI|FI; then flag_c=1, flag_z=0.
//   Next JC: step 2 = IO|J.  Next JZ: step 2 = 0.
//  NOP: steps go 0,1,0; OUT takes 3 cycles.
//   Force an opcode with LEN > STEPS, STEPS=4: step wraps from 3 to 0.
//  HLT: the edge after step 2 gives halted=1 and ctrl_word=0 for 10 cycles.
//   Pulse resume: halted=0 and ctrl_word=MI|CO on the next cycle.
//  run_mode=0, step_req held high 5 cycles: exactly one advance, and adv=1 for one cycle.
//   The other 4 cycles: ctrl_word=0 while ctrl_raw is nonzero.
//  rst asserted at ADD step 3: the next cycle gives step=0, flag_c=0, flag_z=0, halted=0.

Source files
------------

// File: rtl/be_pkg.sv
// rtl/be_pkg.sv - opcodes, control-word bit indices, FSM states and per-opcode step lengths
package be_pkg;

   localparam int OP_NOP = 0;
   localparam int OP_LDA = 1;
   localparam int OP_ADD = 2;
   localparam int OP_SUB = 3;
   localparam int OP_STA = 4;
   localparam int OP_LDI = 5;
   localparam int OP_JMP = 6;
   localparam int OP_JC  = 7;
   localparam int OP_JZ  = 8;
   localparam int OP_OUT = 14;
   localparam int OP_HLT = 15;

   localparam int B_J   = 0;
   localparam int B_CO  = 1;
   localparam int B_CE  = 2;
   localparam int B_OI  = 3;
   localparam int B_BI  = 4;
   localparam int B_SU  = 5;
   localparam int B_SO  = 6;
   localparam int B_AO  = 7;
   localparam int B_AI  = 8;
   localparam int B_II  = 9;
   localparam int B_IO  = 10;
   localparam int B_RO  = 11;
   localparam int B_RI  = 12;
   localparam int B_MI  = 13;
   localparam int B_HLT = 14;
   localparam int B_FI  = 15;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } be_state_t;

   // Total microsteps including the two fetch steps; unknown opcodes behave as NOP.
   function automatic int be_len(input int op);
      case (op)
         OP_NOP:                                       return 2;
         OP_LDA, OP_STA:                               return 4;
         OP_ADD, OP_SUB:                               return 5;
         OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: return 3;
         default:                                      return 2;
      endcase
   endfunction

endpackage

// File: rtl/be_sequencer_if.sv
// rtl/be_sequencer_if.sv - bundle between instruction register / datapath and the sequencer
interface be_sequencer_if #(
   parameter int OPW   = 4,
   parameter int STEPS = 8,
   parameter int CW    = 16
);
   localparam int SW = $clog2(STEPS);

   logic [OPW-1:0] opcode;
   logic           alu_carry;
   logic           alu_zero;
   logic           run_mode;
   logic           step_req;
   logic           resume;
   logic [CW-1:0]  ctrl_word;
   logic [CW-1:0]  ctrl_raw;
   logic           adv;
   logic [SW-1:0]  step;
   logic           halted;
   logic           flag_c;
   logic           flag_z;

   modport master (
      output opcode, alu_carry, alu_zero, run_mode, step_req, resume,
      input  ctrl_word, ctrl_raw, adv, step, halted, flag_c, flag_z
   );

   modport slave (
      input  opcode, alu_carry, alu_zero, run_mode, step_req, resume,
      output ctrl_word, ctrl_raw, adv, step, halted, flag_c, flag_z
   );
endinterface

// File: rtl/be_microcode_rom.sv
// rtl/be_microcode_rom.sv - combinational microcode decode (step, opcode, flags) -> control word
module be_microcode_rom
   import be_pkg::*;
#(
   parameter int OPW = 4,
   parameter int SW  = 3,
   parameter int CW  = 16
) (
   input  logic [SW-1:0]  step,
   input  logic [OPW-1:0] opcode,
   input  logic           flag_c,
   input  logic           flag_z,
   output logic [CW-1:0]  ctrl_raw
);
   logic [15:0] w;

   always_comb begin
      w = '0;
      if (int'(step) == 0) begin
         w[B_MI] = 1'b1;
         w[B_CO] = 1'b1;
      end else if (int'(step) == 1) begin
         w[B_RO] = 1'b1;
         w[B_II] = 1'b1;
         w[B_CE] = 1'b1;
      end else begin
         case (int'(opcode))
            OP_LDA: begin
               if (int'(step) == 2) begin w[B_IO] = 1'b1; w[B_MI] = 1'b1; end
               if (int'(step) == 3) begin w[B_RO] = 1'b1; w[B_AI] = 1'b1; end
            end
            OP_ADD, OP_SUB: begin
               if (int'(step) == 2) begin w[B_IO] = 1'b1; w[B_MI] = 1'b1; end
               if (int'(step) == 3) begin w[B_RO] = 1'b1; w[B_BI] = 1'b1; end
               if (int'(step) == 4) begin w[B_SO] = 1'b1; w[B_AI] = 1'b1; w[B_FI] = 1'b1; end
               // SUB shares ADD's microcode with the subtract line held through execute
               if (int'(opcode) == OP_SUB && int'(step) <= 4) w[B_SU] = 1'b1;
            end
            OP_STA: begin
               if (int'(step) == 2) begin w[B_IO] = 1'b1; w[B_MI] = 1'b1; end
               if (int'(step) == 3) begin w[B_AO] = 1'b1; w[B_RI] = 1'b1; end
            end
            OP_LDI: if (int'(step) == 2) begin w[B_IO] = 1'b1; w[B_AI] = 1'b1; end
            OP_JMP: if (int'(step) == 2) begin w[B_IO] = 1'b1; w[B_J] = 1'b1; end
            OP_JC:  if (int'(step) == 2 && flag_c) begin w[B_IO] = 1'b1; w[B_J] = 1'b1; end
            OP_JZ:  if (int'(step) == 2 && flag_z) begin w[B_IO] = 1'b1; w[B_J] = 1'b1; end
            OP_OUT: if (int'(step) == 2) begin w[B_AO] = 1'b1; w[B_OI] = 1'b1; end
            OP_HLT: if (int'(step) == 2) w[B_HLT] = 1'b1;
            default: ;
         endcase
      end
   end

   assign ctrl_raw = CW'(w);
endmodule

// File: rtl/be_sequencer.sv
// rtl/be_sequencer.sv - microcode sequencer top: step counter, RUN/HALT FSM, flags, step_req edge detect
module be_sequencer
   import be_pkg::*;
#(
   parameter int OPW   = 4,
   parameter int STEPS = 8,
   parameter int CW    = 16
) (
   input logic           CLK,
   input logic           rst,
   be_sequencer_if.slave bus
);
   localparam int SW = $clog2(STEPS);

   be_state_t     state, state_nxt;
   logic [SW-1:0] step, step_nxt;
   logic          flag_c, flag_z, flag_c_nxt, flag_z_nxt;
   logic          step_req_q;
   logic          adv;
   logic [CW-1:0] raw;

   be_microcode_rom #(.OPW(OPW), .SW(SW), .CW(CW)) u_rom (
      .step     (step),
      .opcode   (bus.opcode),
      .flag_c   (flag_c),
      .flag_z   (flag_z),
      .ctrl_raw (raw)
   );

   assign adv = (state == ST_RUN) & (bus.run_mode | (bus.step_req & ~step_req_q));

   always_ff @(posedge CLK) begin
      if (rst) begin
         state      <= ST_RUN;
         step       <= '0;
         flag_c     <= 1'b0;
         flag_z     <= 1'b0;
         step_req_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         step       <= step_nxt;
         flag_c     <= flag_c_nxt;
         flag_z     <= flag_z_nxt;
         step_req_q <= bus.step_req;
      end
   end

   always_comb begin
      state_nxt  = state;
      step_nxt   = step;
      flag_c_nxt = flag_c;
      flag_z_nxt = flag_z;
      case (state)
         ST_RUN: begin
            if (adv) begin
               if (raw[B_FI]) begin
                  flag_c_nxt = bus.alu_carry;
                  flag_z_nxt = bus.alu_zero;
               end
               if (raw[B_HLT]) begin
                  state_nxt = ST_HALT;
                  step_nxt  = '0;
               end else if (int'(step) == STEPS - 1 ||
                            int'(step) == be_len(int'(bus.opcode)) - 1) begin
                  step_nxt = '0;
               end else begin
                  step_nxt = step + SW'(1);
               end
            end
         end
         ST_HALT: begin
            if (bus.resume) begin
               state_nxt = ST_RUN;
               step_nxt  = '0;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      bus.ctrl_raw  = raw;
      bus.ctrl_word = adv ? raw : '0;
      bus.adv       = adv;
      bus.step      = step;
      bus.halted    = (state == ST_HALT);
      bus.flag_c    = flag_c;
      bus.flag_z    = flag_z;
   end
endmodule
